// File: rtl/d_to_t_counter_pkg.sv
// rtl/d_to_t_counter_pkg.sv - shared types for the D-to-T up/down counter
// Purpose: direction encoding and default width used by the counter and its users.
// Ports: none (package).
package d_to_t_counter_pkg;

  localparam int DTC_DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/d_to_t_counter_if.sv
// rtl/d_to_t_counter_if.sv - control/observation bundle of the D-to-T counter
// Purpose: groups count controls (en, up, load, d) and counter outputs (q, t, tc, wrap).
// Ports: master drives en/up/load/d and observes q/t/tc/wrap; slave is the counter side.
interface d_to_t_counter_if #(
  parameter int WIDTH = d_to_t_counter_pkg::DTC_DEFAULT_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, d,
    input  q, t, tc, wrap
  );

  modport slave (
    input  en, up, load, d,
    output q, t, tc, wrap
  );
endinterface

// File: rtl/d_to_t_counter_t_ff_from_d.sv
// rtl/d_to_t_counter_t_ff_from_d.sv - one toggle flip-flop built from a D flip-flop
// Purpose: q toggles on rising clk when t=1, holds when t=0.
// Ports: clk (rising edge), rst (async active-high, clears q), t (toggle request), q (state).
module t_ff_from_d (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // XOR feedback turns the plain D input into a toggle input.
  logic d_next;
  assign d_next = q ^ t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d_next;
    end
  end

endmodule

// File: rtl/d_to_t_counter.sv
// rtl/d_to_t_counter.sv - up/down binary counter made of toggle flip-flops
// Purpose: modulo-2^WIDTH counter with parallel load; every state change is a toggle vector.
// Ports: clk (rising edge), rst (async active-high), bus.slave:
//   en/up/load/d in; q counter value, t next toggle vector, tc terminal count, wrap wrap pulse out.
module d_to_t_counter
  import d_to_t_counter_pkg::*;
#(
  parameter int WIDTH = DTC_DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  d_to_t_counter_if.slave     bus
);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] ones_below;   // ones_below[i] = all lower bits are 1
  logic [WIDTH-1:0] zeros_below;  // zeros_below[i] = all lower bits are 0
  logic             at_max;
  logic             at_min;
  logic             tc_int;
  logic             wrap_q;

  assign ones_below[0]  = 1'b1;
  assign zeros_below[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_prefix
    assign ones_below[i]  = &q_int[i-1:0];
    assign zeros_below[i] = ~|q_int[i-1:0];
  end

  assign at_max = &q_int;
  assign at_min = ~|q_int;

  // Priority load > count > hold. A load is expressed as the toggles that turn q into d.
  always_comb begin
    t_vec = '0;
    if (bus.load) begin
      t_vec = q_int ^ bus.d;
    end else if (bus.en) begin
      if (dir_e'(bus.up) == DIR_UP) begin
        t_vec = ones_below;
      end else begin
        t_vec = zeros_below;
      end
    end
  end

  assign tc_int = bus.en & ~bus.load & ((dir_e'(bus.up) == DIR_UP) ? at_max : at_min);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_from_d u_bit (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q_int[i])
    );
  end

  // tc already excludes load, so a load can never raise wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc_int;
    end
  end

  assign bus.q    = q_int;
  assign bus.t    = t_vec;
  assign bus.tc   = tc_int;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_d_to_t_counter.sv
// tb/tb_d_to_t_counter.sv - self-checking bench for d_to_t_counter
module tb_d_to_t_counter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] mq;
  logic       mwrap;

  d_to_t_counter_if #(.WIDTH(4)) bus ();

  d_to_t_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modulo-16 arithmetic. Returns {wrapped, next value}.
  function automatic logic [4:0] ref_next(input logic [3:0] cur, input logic e, input logic u,
                                          input logic l, input logic [3:0] dv);
    int v;
    logic w;
    v = int'(cur);
    w = 1'b0;
    if (l) begin
      v = int'(dv);
    end else if (e) begin
      v = u ? v + 1 : v - 1;
      w = (v > 15) || (v < 0);
    end
    v = (v + 16) % 16;
    return {w, v[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] dv);
    bus.en   = e;
    bus.up   = u;
    bus.load = l;
    bus.d    = dv;
  endtask

  // Checks t/tc before the edge, advances one edge, then checks q/wrap.
  task automatic tick();
    logic [4:0] r;
    #1;
    r = ref_next(mq, bus.en, bus.up, bus.load, bus.d);
    chk("t", {28'd0, bus.t}, {28'd0, mq ^ r[3:0]});
    chk("tc", {31'd0, bus.tc}, {31'd0, r[4]});
    @(posedge clk);
    #1;
    mq    = r[3:0];
    mwrap = r[4];
    chk("q", {28'd0, bus.q}, {28'd0, mq});
    chk("wrap", {31'd0, bus.wrap}, {31'd0, mwrap});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    mq = 4'h0;
    mwrap = 1'b0;
    #3;
    chk("reset_q", {28'd0, bus.q}, 32'h0);
    chk("reset_wrap", {31'd0, bus.wrap}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges with q=9, then ten up-counts.
    drive(1'b0, 1'b0, 1'b1, 4'h9);
    tick();
    chk("load9", {28'd0, bus.q}, 32'h9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", {28'd0, bus.q}, 32'h0);
    chk("async_rst_wrap", {31'd0, bus.wrap}, 32'h0);
    mq = 4'h0;
    mwrap = 1'b0;
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    repeat (10) tick();
    chk("ten_up", {28'd0, bus.q}, 32'hA);

    // Up wrap.
    drive(1'b0, 1'b0, 1'b1, 4'hE);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    #1;
    chk("upwrap_tc", {31'd0, bus.tc}, 32'h1);
    tick();
    chk("upwrap_q0", {28'd0, bus.q}, 32'h0);
    chk("upwrap_wrap", {31'd0, bus.wrap}, 32'h1);
    tick();
    chk("upwrap_q1", {28'd0, bus.q}, 32'h1);
    chk("upwrap_wrap_clr", {31'd0, bus.wrap}, 32'h0);

    // Down wrap.
    drive(1'b0, 1'b0, 1'b1, 4'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    chk("dnwrap_tc", {31'd0, bus.tc}, 32'h1);
    chk("dnwrap_t", {28'd0, bus.t}, 32'hF);
    tick();
    chk("dnwrap_q", {28'd0, bus.q}, 32'hF);
    chk("dnwrap_wrap", {31'd0, bus.wrap}, 32'h1);

    // Load priority, then load of the current value.
    drive(1'b0, 1'b0, 1'b1, 4'h3);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'hC);
    #1;
    chk("ldpri_t", {28'd0, bus.t}, 32'hF);
    tick();
    chk("ldpri_q", {28'd0, bus.q}, 32'hC);
    chk("ldpri_wrap", {31'd0, bus.wrap}, 32'h0);
    #1;
    chk("ldsame_t", {28'd0, bus.t}, 32'h0);
    tick();
    chk("ldsame_q", {28'd0, bus.q}, 32'hC);

    // Direction change and hold.
    drive(1'b0, 1'b0, 1'b1, 4'h5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    tick();
    chk("dir_q7", {28'd0, bus.q}, 32'h7);
    bus.up = 1'b0;
    tick();
    chk("dir_q6", {28'd0, bus.q}, 32'h6);
    tick();
    chk("dir_q5", {28'd0, bus.q}, 32'h5);
    bus.en = 1'b0;
    repeat (3) tick();
    chk("hold_q", {28'd0, bus.q}, 32'h5);
    chk("hold_t", {28'd0, bus.t}, 32'h0);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
            4'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        mq = 4'h0;
        mwrap = 1'b0;
        chk("rnd_rst_q", {28'd0, bus.q}, 32'h0);
        chk("rnd_rst_wrap", {31'd0, bus.wrap}, 32'h0);
        rst = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
